// File: rtl/sram_result_reader_pkg.sv
// -----------------------------------------------------------------------------
// sram_result_reader_pkg
// Shared constants for the SRAM result reader: SRAM address/data widths,
// output buffer depth and the FSM state encodings.
// -----------------------------------------------------------------------------
package sram_result_reader_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 128;
  // Output buffer depth. The credit rule and result_fifo2 assume exactly 2.
  localparam int BUF_DEPTH = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/sram_result_reader_if.sv
// -----------------------------------------------------------------------------
// sram_result_reader_if
// Bundles the drain control, SRAM read-port-1 and output stream signals.
//   master : the reader (drives ReadAddress1, out_valid/out_data, busy, done)
//   slave  : the environment (drives start/start_addr/word_count, ReadBus1,
//            out_ready)
// -----------------------------------------------------------------------------
interface sram_result_reader_if;
  import sram_result_reader_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] word_count;
  logic [ADDR_W-1:0] ReadAddress1;
  logic [DATA_W-1:0] ReadBus1;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, start_addr, word_count, ReadBus1, out_ready,
    output ReadAddress1, out_valid, out_data, busy, done
  );

  modport slave (
    output start, start_addr, word_count, ReadBus1, out_ready,
    input  ReadAddress1, out_valid, out_data, busy, done
  );

endinterface

// File: rtl/sram_result_reader_fifo2.sv
// -----------------------------------------------------------------------------
// result_fifo2
// Two-entry DATA_W FIFO holding SRAM read data until the stream consumer
// accepts it. Entry 0 is always the head, so head_data_o needs no read mux.
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   push_i         write push_data_i at the tail
//   push_data_i    data to write
//   pop_i          drop the head entry (caller guarantees count_o != 0)
//   head_data_o    current head entry
//   count_o        number of valid entries (0..2)
// -----------------------------------------------------------------------------
module result_fifo2
  import sram_result_reader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] ent0_q, ent0_d;
  logic [DATA_W-1:0] ent1_q, ent1_d;
  logic [1:0]        count_q, count_d;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (count_q == 2'd0) ent0_d = push_data_i;
        else                 ent1_d = push_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop: count is unchanged, the queue shifts by one.
        if (count_q == 2'd1) begin
          ent0_d = push_data_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign head_data_o = ent0_q;
  assign count_o     = count_q;

endmodule

// File: rtl/sram_result_reader.sv
// -----------------------------------------------------------------------------
// sram_result_reader
// Reads word_count consecutive SRAM words starting at start_addr through
// read port 1 and presents them, in address order, as a valid/ready stream.
// Ports:
//   clock, reset  clock and asynchronous active-high reset
//   bus (master)  start/start_addr/word_count request, ReadAddress1/ReadBus1
//                 SRAM read port, out_valid/out_data/out_ready stream,
//                 busy/done status
// -----------------------------------------------------------------------------
module sram_result_reader
  import sram_result_reader_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  sram_result_reader_if.master bus
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] raddr_q;
  logic              inflight_q;

  logic [1:0]        buf_count;
  logic [1:0]        buf_count_next;
  logic [DATA_W-1:0] buf_head;
  logic              pop;
  logic              issue;
  logic [2:0]        occupancy;

  assign pop = (buf_count != 2'd0) && bus.out_ready;

  // Entries the buffer will hold after this edge if nothing new is issued.
  // Counting this cycle's pop keeps one word per cycle flowing while the
  // consumer is ready, and still bounds buffer + in-flight at BUF_DEPTH.
  assign occupancy = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == ST_RUN) && (rem_q != '0) &&
                     (occupancy < 3'(BUF_DEPTH));

  assign buf_count_next = buf_count + {1'b0, inflight_q} - {1'b0, pop};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          addr_d  = bus.start_addr;
          rem_d   = bus.word_count;
          // A zero-length drain spends one busy cycle in DRAIN (which is
          // already empty) before FINISH pulses done.
          state_d = (bus.word_count == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - ADDR_W'(1);
        end
        if (rem_q == '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave on the edge of the final handshake so done follows it by one.
        if (!inflight_q && (buf_count_next == 2'd0)) state_d = ST_FINISH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      raddr_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= issue;
      if (issue) raddr_q <= addr_q;
    end
  end

  // SRAM registers the address at the end of the issue cycle, so the
  // address is presented combinationally and held afterwards.
  assign bus.ReadAddress1 = issue ? addr_q : raddr_q;

  result_fifo2 u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (bus.ReadBus1),
    .pop_i       (pop),
    .head_data_o (buf_head),
    .count_o     (buf_count)
  );

  assign bus.out_valid = (buf_count != 2'd0);
  assign bus.out_data  = buf_head;
  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.done      = (state_q == ST_FINISH);

endmodule
